// File: rtl/wishbone_test_ram_pkg.sv
// Shared definitions for the Wishbone test RAM: FSM encodings and a
// constant ceil-log2 used for byte-offset and counter sizing.
package wishbone_test_ram_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wishbone_test_ram_array.sv
// Byte-lane-writable synchronous RAM with a registered read-before-write port;
// one narrow memory per lane so synthesis maps it onto byte-enable block RAM.
module wishbone_test_ram_array #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [DATA_WIDTH/8-1:0]   lane_we,
  input  logic [ADDRESS_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     rdata
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk)
      if (en && lane_we[l]) mem[addr] <= wdata[l*8 +: 8];

    // Only the output register is reset; the array contents are not.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  rdata[l*8 +: 8] <= '0;
      else if (en) rdata[l*8 +: 8] <= mem[addr];
  end

endmodule

// File: rtl/wishbone_test_ram.sv
// Wishbone single-port RAM slave with configurable wait states, byte-lane
// writes, a one-cycle ack per transfer and abort on strobe drop.
module wishbone_test_ram
  import wishbone_test_ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int WAIT_STATES   = 0
) (
  input  logic                    pinClock,
  input  logic                    pinResetN,
  input  logic                    pinWbCycleStrobe,
  input  logic                    pinWbWriteEnable,
  input  logic [31:0]             pinWbAddress,
  input  logic [DATA_WIDTH/8-1:0] pinWbSelect,
  input  logic [DATA_WIDTH-1:0]   pinWbWriteData,
  output logic [DATA_WIDTH-1:0]   pinWbReadData,
  output logic                    pinWbAck,
  output logic                    pinBusy
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int B     = clog2(LANES);
  localparam int CW    = (WAIT_STATES > 0) ? clog2(WAIT_STATES + 1) : 1;

  logic [1:0]               state, state_nxt;
  logic [CW-1:0]            cnt, cnt_nxt;
  logic                     access;
  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic [LANES-1:0]         lane_we;
  logic [31:0]              unused_addr;

  assign word_addr   = pinWbAddress[ADDRESS_WIDTH+B-1:B];
  assign unused_addr = pinWbAddress;
  assign lane_we     = {LANES{access & pinWbWriteEnable}} & pinWbSelect;

  // The RAM is touched only on the edge that moves the FSM into ACK.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = 1'b0;
    case (state)
      ST_IDLE:
        if (pinWbCycleStrobe) begin
          cnt_nxt = CW'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_nxt = ST_ACK;
            access    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      ST_WAIT:
        if (!pinWbCycleStrobe) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nxt = ST_ACK;
            access    = 1'b1;
          end
        end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pinClock or negedge pinResetN)
    if (!pinResetN) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pinWbAck <= 1'b0;
      pinBusy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pinWbAck <= (state_nxt == ST_ACK);
      pinBusy  <= (state_nxt != ST_IDLE);
    end

  wishbone_test_ram_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_array (
    .clk     (pinClock),
    .rst_n   (pinResetN),
    .en      (access),
    .lane_we (lane_we),
    .addr    (word_addr),
    .wdata   (pinWbWriteData),
    .rdata   (pinWbReadData)
  );

endmodule

// File: tb/tb_wishbone_test_ram.sv
// Bench for wishbone_test_ram: a zero-wait-state and a three-wait-state
// instance driven by directed steps plus random traffic against a word model.
module tb_wishbone_test_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb0 = 1'b0, stb3 = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  sel = '0;
  logic [31:0] rd0, rd3;
  logic        ack0, ack3, busy0, busy3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m0 [256];
  logic [31:0] m3 [16];
  bit          v0 [256];
  bit          v3 [16];

  always #5 clk = ~clk;

  wishbone_test_ram #(.DATA_WIDTH(32), .ADDRESS_WIDTH(8), .WAIT_STATES(0)) u0 (
    .pinClock(clk), .pinResetN(rst_n), .pinWbCycleStrobe(stb0), .pinWbWriteEnable(we),
    .pinWbAddress(addr), .pinWbSelect(sel), .pinWbWriteData(wdata),
    .pinWbReadData(rd0), .pinWbAck(ack0), .pinBusy(busy0));

  wishbone_test_ram #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .WAIT_STATES(3)) u3 (
    .pinClock(clk), .pinResetN(rst_n), .pinWbCycleStrobe(stb3), .pinWbWriteEnable(we),
    .pinWbAddress(addr), .pinWbSelect(sel), .pinWbWriteData(wdata),
    .pinWbReadData(rd3), .pinWbAck(ack3), .pinBusy(busy3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transfer: latency, busy and single-pulse ack are checked here.
  task automatic xfer(input bit u, input bit w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd);
    int  n;
    logic ak;
    @(negedge clk);
    we = w; addr = a; sel = s; wdata = d;
    if (u) stb3 = 1'b1; else stb0 = 1'b1;
    n = 0; ak = 1'b0;
    while (!ak && n < 40) begin
      @(posedge clk); #1;
      n++;
      ak = u ? ack3 : ack0;
      if (n == 1) chk("busy_after_first_edge", u ? busy3 : busy0, 1);
    end
    stb0 = 1'b0; stb3 = 1'b0;
    chk("ack_latency", n, u ? 4 : 1);
    rd = u ? rd3 : rd0;
    @(posedge clk); #1;
    chk("ack_single_pulse", u ? ack3 : ack0, 0);
    chk("busy_back_idle", u ? busy3 : busy0, 0);
  endtask

  // Transfer plus model bookkeeping: reads and writes both return the old word.
  task automatic do_op(input bit u, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd);
    int          i;
    logic [31:0] old, nw;
    bit          ok;
    i   = u ? int'((a >> 2) % 16) : int'((a >> 2) % 256);
    old = u ? m3[i] : m0[i];
    ok  = u ? v3[i] : v0[i];
    xfer(u, w, a, s, d, rd);
    if (ok) chk(w ? "rd_before_write" : "read_vs_model", rd, old);
    if (w) begin
      nw = old;
      for (int b = 0; b < 4; b++) if (s[b]) nw[b*8 +: 8] = d[b*8 +: 8];
      if (u) begin m3[i] = nw; v3[i] = ok || (s == 4'hF); end
      else   begin m0[i] = nw; v0[i] = ok || (s == 4'hF); end
    end
  endtask

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) v0[i] = 1'b0;
    for (int i = 0; i < 16; i++)  v3[i] = 1'b0;

    #12;
    chk("reset_ack0", ack0, 0);  chk("reset_busy0", busy0, 0);  chk("reset_rd0", rd0, 0);
    chk("reset_ack3", ack3, 0);  chk("reset_busy3", busy3, 0);  chk("reset_rd3", rd3, 0);
    @(negedge clk); rst_n = 1'b1;

    // Zero wait states: full write then read back.
    do_op(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, rd);
    do_op(0, 0, 32'h10, 4'h0, 32'h0, rd);
    chk("read_deadbeef", rd, 32'hDEADBEEF);

    // Byte lanes with read-before-write on the partial write.
    do_op(0, 1, 32'h20, 4'hF, 32'h11223344, rd);
    do_op(0, 1, 32'h20, 4'h5, 32'hAABBCCDD, rd);
    chk("partial_write_old_word", rd, 32'h11223344);
    do_op(0, 0, 32'h20, 4'h0, 32'h0, rd);
    chk("byte_lane_merge", rd, 32'h11BB33DD);

    // Continuous strobe with three wait states: acks at 4, 9, 14.
    do_op(1, 1, 32'h08, 4'hF, 32'h0BADF00D, rd);
    @(negedge clk);
    we = 1'b0; addr = 32'h08; sel = 4'h0; stb3 = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      chk("cont_ack", ack3, (n == 4 || n == 9 || n == 14));
      chk("cont_busy", busy3, !(n == 5 || n == 10));
      if (n == 4 || n == 9 || n == 14) chk("cont_read", rd3, 32'h0BADF00D);
    end
    stb3 = 1'b0;
    @(posedge clk); #1;
    chk("cont_ack_end", ack3, 0);

    // Abort: strobe dropped while waiting leaves memory untouched.
    do_op(1, 1, 32'h30, 4'hF, 32'h0000CAFE, rd);
    @(negedge clk);
    we = 1'b1; addr = 32'h30; sel = 4'hF; wdata = 32'h55; stb3 = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      chk("abort_no_ack_pre", ack3, 0);
    end
    stb3 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      chk("abort_no_ack_post", ack3, 0);
    end
    chk("abort_busy_clear", busy3, 0);
    do_op(1, 0, 32'h30, 4'h0, 32'h0, rd);
    chk("abort_kept_value", rd, 32'h0000CAFE);

    // Asynchronous reset while a write is waiting.
    do_op(1, 1, 32'h38, 4'hF, 32'hA5A5A5A5, rd);
    @(negedge clk);
    we = 1'b1; addr = 32'h38; sel = 4'hF; wdata = 32'hFFFFFFFF; stb3 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", busy3, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", ack3, 0);
    chk("async_rst_busy", busy3, 0);
    chk("async_rst_rd", rd3, 0);
    stb3 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_op(1, 0, 32'h38, 4'h0, 32'h0, rd);
    chk("reset_dropped_write", rd, 32'hA5A5A5A5);

    // Aliasing on the 16-word instance.
    do_op(1, 1, 32'h04, 4'hF, 32'h00001234, rd);
    do_op(1, 0, 32'h44, 4'h0, 32'h0, rd);
    chk("alias_read", rd, 32'h00001234);

    // Random traffic over a prefilled region of both instances.
    for (int i = 0; i < 16; i++) begin
      do_op(0, 1, 32'(i) << 2, 4'hF, $urandom, rd);
      do_op(1, 1, 32'(i) << 2, 4'hF, $urandom, rd);
    end
    for (int k = 0; k < 60; k++) begin
      bit          u, w;
      logic [31:0] a;
      u = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = u ? $urandom : ($urandom & 32'hFFFFFC3F);
      do_op(u, w, a, 4'($urandom_range(0, 15)), $urandom, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_test_ram.md
# wishbone_test_ram

Parametrised Wishbone-style single-port RAM slave used as the bus target behind test controllers such as the RAM test controller on the FPGA board. It replaces the fixed 256x32 toggling-ack test memory with configurable data width, depth and wait states, byte-lane writes, a proper one-pulse-per-transfer acknowledge and strobe-abort handling. It sits between a bus master (test controller, CPU) and on-chip block RAM.

## Interface

- DATA_WIDTH, 32, data bus width in bits; multiple of 8, 8..64.
- ADDRESS_WIDTH, 8, word-address bits; depth = 2^ADDRESS_WIDTH words.
- WAIT_STATES, 0, extra cycles before ack; 0..15.

- pinClock  in  1  single clock; all logic on rising edge.
- pinResetN  in  1  asynchronous, active-low reset.
- pinWbCycleStrobe  in  1  combined cycle/strobe; request valid.
- pinWbWriteEnable  in  1  1 = write, 0 = read.
- pinWbAddress  in  32  byte address; word index = bits [ADDRESS_WIDTH+B-1 : B], B = log2(DATA_WIDTH/8); other bits ignored (aliasing).
- pinWbSelect  in  DATA_WIDTH/8  byte-lane write enables; ignored on reads.
- pinWbWriteData  in  DATA_WIDTH  write data.
- pinWbReadData  out  DATA_WIDTH  registered read data; valid in ack cycle.
- pinWbAck  out  1  registered one-cycle acknowledge.
- pinBusy  out  1  high while a transfer is in progress (WAIT or ACK state).

## Operation

- FSM states IDLE, WAIT, ACK; reset state IDLE.
- IDLE: strobe=1 → load wait counter with WAIT_STATES; go ACK if WAIT_STATES=0, else WAIT.
- WAIT: strobe=0 → abort to IDLE, no memory access, no ack. Otherwise decrement counter; when counter reaches 1 → ACK.
- Memory access occurs on the edge that enters ACK, using live bus signals (master holds address/data/we/select stable while strobe is high until ack).
  - Write: lanes with select=1 updated; others unchanged. pinWbReadData gets pre-write word (read-before-write).
  - Read: pinWbReadData gets addressed word; memory unchanged.
- ACK: pinWbAck=1 for exactly one cycle; unconditionally → IDLE. Strobe still high in the next IDLE cycle is treated as a new transfer.
- pinWbReadData holds its value until the next access; it is not cleared after ack.
- RAM contents are not reset; initial contents undefined (simulation: X).
- Asynchronous reset mid-transfer: FSM → IDLE, counter → 0, pinWbAck → 0, pinBusy → 0, pinWbReadData → 0; a pending write is dropped (write completes only on the edge entering ACK).

## Timing

- Reset values: pinWbAck=0, pinBusy=0, pinWbReadData=0.
- Strobe first sampled high at edge E0 → pinWbAck high in the cycle after edge E(WAIT_STATES), low after the next edge.
- Latency strobe-to-ack: WAIT_STATES+1 edges; throughput under continuous strobe: one transfer per WAIT_STATES+2 cycles.
- pinBusy is registered: high from the cycle after E0 through the ack cycle.
- Strobe dropped in the same cycle the FSM enters ACK has no effect; the access has already committed and ack still pulses.

## Structure

- Shared package/header: FSM state encodings (2 bits) and a log2 constant function for B and counter width.
- Sub-module wishbone_test_ram_array: synchronous byte-lane-writable RAM. It takes clock, enable, per-lane write enables, word address, write data, and registered read-before-write output, so synthesis infers block RAM. The top-level module holds the FSM, counter and ack logic.

## Test plan

- DATA_WIDTH=32, WAIT_STATES=0: write 0xDEADBEEF to byte address 0x10 with select=0xF, then read 0x10 → ack 1 cycle after each strobe edge; read data 0xDEADBEEF; exactly one ack pulse per transfer.
- Byte lanes: write 0x11223344 to 0x20, then write 0xAABBCCDD with select=0x5, then read → 0x11BB33DD. The second write's ack cycle shows read data 0x11223344.
- WAIT_STATES=3: hold strobe continuously for 3 reads → acks 4, 9, 14 cycles after the first strobe edge; pinBusy low only in the IDLE cycles between transfers.
- Abort: WAIT_STATES=5, write 0x55 to 0x30, drop strobe after 2 cycles, then read 0x30 → no ack for the aborted write; location still holds its prior value 0x0000CAFE.
- Reset mid-transfer: WAIT_STATES=4, assert pinResetN=0 during WAIT with a write pending → outputs 0 immediately (asynchronous), no ack. After release, a read shows the target unchanged.
- Aliasing, ADDRESS_WIDTH=4: write 0x1234 to address 0x04, read 0x44 → 0x1234.
